// File: rtl/window_addr_scan.sv
// window_addr_scan
//    Scans a WIN_H x WIN_V window over an IMG_H x IMG_V row-major image in
//    raster order (x fastest) with steps of STRIDE_H / STRIDE_V. It emits the
//    pixel addresses of every window position over a valid/ready handshake.
//    MODE=0 presents one whole window per beat. MODE=1 presents one address
//    per beat, in row-major element order. All address arithmetic wraps
//    modulo 2^ADDR_W.
//
// Ports
//    clk, rst      rising-edge clock, asynchronous active-high reset
//    start         one-cycle pulse; begins a scan when idle
//    pause         holds off new beats while high (ignored during a stall)
//    base_addr_in  image base address, latched on start
//    out_ready     consumer accepts the presented beat
//    out_valid     beat valid
//    addr_out      element k = i*WIN_H + j at [ADDR_W*(k+1)-1 : ADDR_W*k];
//                  MODE=1 drives only element 0
//    elem_idx      MODE=1: element index of the current address; MODE=0: 0
//    win_first     beat belongs to window position (0,0)
//    win_last      final beat of the scan
//    busy          scan in progress
//    done          one-cycle pulse after the final beat is accepted
module window_addr_scan #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned WIN_H    = 5,
   parameter int unsigned WIN_V    = 5,
   parameter int unsigned IMG_H    = 35,
   parameter int unsigned IMG_V    = 35,
   parameter int unsigned STRIDE_H = 1,
   parameter int unsigned STRIDE_V = 1,
   parameter int unsigned MODE     = 0,
   localparam int unsigned IDX_W   = (WIN_H * WIN_V > 1) ? $clog2(WIN_H * WIN_V) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            pause,
   input  logic [ADDR_W-1:0]               base_addr_in,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [ADDR_W*WIN_H*WIN_V-1:0]   addr_out,
   output logic [IDX_W-1:0]                elem_idx,
   output logic                            win_first,
   output logic                            win_last,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned N  = WIN_H * WIN_V;
   localparam int unsigned NX = (IMG_H - WIN_H) / STRIDE_H + 1;
   localparam int unsigned NY = (IMG_V - WIN_V) / STRIDE_V + 1;
   localparam int unsigned XW = (NX > 1) ? $clog2(NX) : 1;
   localparam int unsigned YW = (NY > 1) ? $clog2(NY) : 1;

   localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE_H);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE_V * IMG_H);

   // Constant offset of window element k relative to the anchor pixel.
   function automatic logic [ADDR_W-1:0] elem_off(input int unsigned k);
      return ADDR_W'((k / WIN_H) * IMG_H + (k % WIN_H));
   endfunction

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               load, advance;
   logic               pos_last, k_last, last_beat;
   logic [ADDR_W-1:0]  row_base_q;   // anchor of x=0 on the current row
   logic [ADDR_W-1:0]  anchor_q;
   logic [XW-1:0]      x_q;
   logic [YW-1:0]      y_q;
   logic [IDX_W-1:0]   k_q;

   assign pos_last  = (x_q == XW'(NX - 1)) && (y_q == YW'(NY - 1));
   assign k_last    = (MODE == 0) || (k_q == IDX_W'(N - 1));
   assign last_beat = pos_last && k_last;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      load    = 1'b0;
      advance = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // done high means the previous scan just ended; start is dropped.
            if (start && !done_q) begin
               load    = 1'b1;
               state_d = S_RUN;
               valid_d = !pause;
            end
         end
         S_RUN: begin
            if (valid_q) begin
               if (out_ready) begin
                  if (last_beat) begin
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     advance = 1'b1;
                     valid_d = !pause;
                  end
               end
            end else begin
               valid_d = !pause;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         row_base_q <= '0;
         anchor_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
         k_q        <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         if (load) begin
            row_base_q <= base_addr_in;
            anchor_q   <= base_addr_in;
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
         end else if (advance) begin
            if (!k_last) begin
               k_q <= k_q + 1'b1;
            end else begin
               k_q <= '0;
               if (x_q == XW'(NX - 1)) begin
                  x_q        <= '0;
                  y_q        <= y_q + 1'b1;
                  row_base_q <= row_base_q + ROW_STEP;
                  anchor_q   <= row_base_q + ROW_STEP;
               end else begin
                  x_q      <= x_q + 1'b1;
                  anchor_q <= anchor_q + COL_STEP;
               end
            end
         end
      end
   end

   assign out_valid = valid_q;
   assign done      = done_q;
   assign busy      = (state_q != S_IDLE);
   // Flags and addresses are qualified by out_valid so idle outputs read zero.
   assign win_first = valid_q && (x_q == '0) && (y_q == '0);
   assign win_last  = valid_q && last_beat;

   if (MODE == 0) begin : g_par
      for (genvar k = 0; k < N; k++) begin : g_elem
         assign addr_out[ADDR_W*k +: ADDR_W] = valid_q ? (anchor_q + elem_off(k)) : '0;
      end
      assign elem_idx = '0;
   end else begin : g_ser
      logic [ADDR_W-1:0] off_sel;
      always_comb begin
         off_sel = '0;
         for (int unsigned k = 0; k < N; k++) begin
            if (k_q == IDX_W'(k)) off_sel = elem_off(k);
         end
      end
      assign addr_out[ADDR_W-1:0] = valid_q ? (anchor_q + off_sel) : '0;
      if (N > 1) begin : g_pad
         assign addr_out[ADDR_W*N-1:ADDR_W] = '0;
      end
      assign elem_idx = valid_q ? k_q : '0;
   end

endmodule

// File: tb/tb_window_addr_scan.sv
// Bench for window_addr_scan: three instances (default 5x5 over 35x35 parallel;
// 3x3 over 7x6 stride 2 parallel; same geometry serial). A reference model
// expands each scan into its expected beat list; a monitor pops and compares
// every accepted beat, checks stall stability, the done pulse and reset values.
module tb_window_addr_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  start, pause, rdy;
   logic [31:0] base [3];

   logic        ov [3], wf [3], wl [3], bsy [3], dn [3];
   logic [799:0] ao [3];
   logic [7:0]  idx [3];

   logic [799:0] ao0;
   logic [287:0] ao1, ao2;
   logic [4:0]   ix0;
   logic [3:0]   ix1, ix2;

   assign ao[0]  = ao0;
   assign ao[1]  = 800'(ao1);
   assign ao[2]  = 800'(ao2);
   assign idx[0] = 8'(ix0);
   assign idx[1] = 8'(ix1);
   assign idx[2] = 8'(ix2);

   window_addr_scan u_def (
      .clk(clk), .rst(rst), .start(start[0]), .pause(pause[0]),
      .base_addr_in(base[0]), .out_ready(rdy[0]), .out_valid(ov[0]),
      .addr_out(ao0), .elem_idx(ix0), .win_first(wf[0]), .win_last(wl[0]),
      .busy(bsy[0]), .done(dn[0]));

   window_addr_scan #(.WIN_H(3), .WIN_V(3), .IMG_H(7), .IMG_V(6),
                      .STRIDE_H(2), .STRIDE_V(2), .MODE(0)) u_par (
      .clk(clk), .rst(rst), .start(start[1]), .pause(pause[1]),
      .base_addr_in(base[1]), .out_ready(rdy[1]), .out_valid(ov[1]),
      .addr_out(ao1), .elem_idx(ix1), .win_first(wf[1]), .win_last(wl[1]),
      .busy(bsy[1]), .done(dn[1]));

   window_addr_scan #(.WIN_H(3), .WIN_V(3), .IMG_H(7), .IMG_V(6),
                      .STRIDE_H(2), .STRIDE_V(2), .MODE(1)) u_ser (
      .clk(clk), .rst(rst), .start(start[2]), .pause(pause[2]),
      .base_addr_in(base[2]), .out_ready(rdy[2]), .out_valid(ov[2]),
      .addr_out(ao2), .elem_idx(ix2), .win_first(wf[2]), .win_last(wl[2]),
      .busy(bsy[2]), .done(dn[2]));

   typedef struct {
      logic [799:0] a;
      int unsigned  idx;
      bit           first;
      bit           last;
   } beat_t;

   beat_t sb [3][$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input bit ok, input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: every window position, every element, by plain arithmetic.
   task automatic push_scan(input int inst, input logic [31:0] b);
      int wh, wv, ih, iv, sh, sv, md, nx, ny, n;
      logic [31:0] anc;
      bit fin;
      beat_t bt;
      if (inst == 0) begin
         wh = 5; wv = 5; ih = 35; iv = 35; sh = 1; sv = 1; md = 0;
      end else begin
         wh = 3; wv = 3; ih = 7; iv = 6; sh = 2; sv = 2; md = (inst == 2) ? 1 : 0;
      end
      nx = (ih - wh) / sh + 1;
      ny = (iv - wv) / sv + 1;
      n  = wh * wv;
      for (int y = 0; y < ny; y++) begin
         for (int x = 0; x < nx; x++) begin
            anc = b + 32'(y * sv * ih + x * sh);
            fin = (y == ny - 1) && (x == nx - 1);
            if (md == 0) begin
               bt.a = '0;
               for (int k = 0; k < n; k++)
                  bt.a[32*k +: 32] = anc + 32'((k / wh) * ih + k % wh);
               bt.idx = 0; bt.first = (x == 0 && y == 0); bt.last = fin;
               sb[inst].push_back(bt);
            end else begin
               for (int k = 0; k < n; k++) begin
                  bt.a = '0;
                  bt.a[31:0] = anc + 32'((k / wh) * ih + k % wh);
                  bt.idx = k; bt.first = (x == 0 && y == 0);
                  bt.last = fin && (k == n - 1);
                  sb[inst].push_back(bt);
               end
            end
         end
      end
   endtask

   // Monitor state
   bit           exp_done [3] = '{default: 1'b0};
   bit           held     [3] = '{default: 1'b0};
   logic [799:0] hold_a   [3];
   logic [7:0]   hold_idx [3];
   logic         hold_f   [3], hold_l [3];
   int           cnt      [3] = '{default: 0};
   logic [799:0] first_a  [3], last_a [3];
   logic [31:0]  early    [3][4];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            check(!ov[i] && !bsy[i] && !dn[i] && !wf[i] && !wl[i] &&
                  ao[i] == '0 && idx[i] == '0, "rst_zero",
                  {ov[i], bsy[i], dn[i], wf[i], wl[i], |ao[i], |idx[i]}, 64'd0);
            sb[i].delete();
            exp_done[i] = 1'b0;
            held[i]     = 1'b0;
         end else begin
            check(dn[i] == exp_done[i], "done", 64'(dn[i]), 64'(exp_done[i]));
            exp_done[i] = 1'b0;
            if (held[i]) begin
               check(ov[i] && ao[i] == hold_a[i] && idx[i] == hold_idx[i] &&
                     wf[i] == hold_f[i] && wl[i] == hold_l[i], "stall_hold",
                     ao[i][63:0], hold_a[i][63:0]);
            end
            if (start[i] && !bsy[i]) cnt[i] = 0;
            if (ov[i] && rdy[i]) begin
               if (sb[i].size() == 0) begin
                  check(1'b0, "extra_beat", ao[i][63:0], 64'd0);
               end else begin
                  beat_t e;
                  e = sb[i].pop_front();
                  check(ao[i] == e.a, "addr", ao[i][63:0], e.a[63:0]);
                  check(idx[i] == 8'(e.idx), "elem_idx", 64'(idx[i]), 64'(e.idx));
                  check(wf[i] == e.first && wl[i] == e.last, "flags",
                        {wf[i], wl[i]}, {e.first, e.last});
                  exp_done[i] = e.last;
                  if (cnt[i] == 0) first_a[i] = ao[i];
                  if (cnt[i] < 4) early[i][cnt[i]] = ao[i][31:0];
                  last_a[i] = ao[i];
                  cnt[i]++;
               end
            end
            held[i]     = ov[i] && !rdy[i];
            hold_a[i]   = ao[i];
            hold_idx[i] = idx[i];
            hold_f[i]   = wf[i];
            hold_l[i]   = wl[i];
         end
      end
   end

   // Issues one scan. rnd: random ready and pause pulses. abort_at>0: return
   // once that many beats are accepted. poke: re-pulse start while busy.
   // start_on_done: pulse start in the cycle done is high.
   task automatic run_scan(input int inst, input logic [31:0] b, input bit rnd,
                           input int abort_at, input bit poke,
                           input bit start_on_done, input int budget,
                           output int cycles);
      push_scan(inst, b);
      base[inst]  = b;
      rdy[inst]   = 1'b1;
      pause[inst] = 1'b0;
      start[inst] = 1'b1;
      @(posedge clk); #1;
      start[inst] = 1'b0;
      cycles = 0;
      forever begin
         if (rnd) begin
            rdy[inst]   = 1'($urandom_range(0, 1));
            pause[inst] = ($urandom_range(0, 5) == 0);
         end
         start[inst] = poke && (cycles == 3);
         @(posedge clk); #1;
         cycles++;
         if (abort_at > 0 && cnt[inst] >= abort_at) break;
         if (!bsy[inst]) break;
         if (cycles > budget) begin
            check(1'b0, "timeout", 64'(cycles), 64'(budget));
            break;
         end
      end
      start[inst] = 1'b0;
      rdy[inst]   = 1'b1;
      pause[inst] = 1'b0;
      if (abort_at == 0) begin
         if (start_on_done) begin
            start[inst] = 1'b1;
            @(posedge clk); #1;
            start[inst] = 1'b0;
            check(!bsy[inst], "start_on_done", 64'(bsy[inst]), 64'd0);
         end
         repeat (3) @(posedge clk);
         #1;
         check(sb[inst].size() == 0, "all_beats", 64'(sb[inst].size()), 64'd0);
      end
   endtask

   initial begin
      int cyc;
      rst   = 1'b1;
      start = '0;
      pause = '0;
      rdy   = '1;
      for (int i = 0; i < 3; i++) base[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Default geometry, back-to-back
      run_scan(0, 32'h0000_1000, 1'b0, 0, 1'b0, 1'b0, 3000, cyc);
      check(cyc == 961, "t1_cycles", 64'(cyc), 64'd961);
      check(cnt[0] == 961, "t1_beats", 64'(cnt[0]), 64'd961);
      check(first_a[0][31:0] == 32'h1000, "t1_e0", 64'(first_a[0][31:0]), 64'h1000);
      check(first_a[0][24*32 +: 32] == 32'h1090, "t1_e24",
            64'(first_a[0][24*32 +: 32]), 64'h1090);
      check(last_a[0][31:0] == 32'h1000 + 32'd1080, "t1_last_anchor",
            64'(last_a[0][31:0]), 64'(32'h1000 + 32'd1080));

      // Strided 3x3 over 7x6, parallel
      run_scan(1, 32'd100, 1'b0, 0, 1'b0, 1'b0, 500, cyc);
      check(cnt[1] == 6, "t2_beats", 64'(cnt[1]), 64'd6);
      check(first_a[1][31:0] == 32'd100, "t2_first", 64'(first_a[1][31:0]), 64'd100);
      check(last_a[1][8*32 +: 32] == 32'd134, "t2_last_e8",
            64'(last_a[1][8*32 +: 32]), 64'd134);

      // Same geometry, serial
      run_scan(2, 32'd100, 1'b0, 0, 1'b0, 1'b0, 500, cyc);
      check(cnt[2] == 54, "t3_beats", 64'(cnt[2]), 64'd54);
      check(early[2][1] == 32'd101, "t3_beat1", 64'(early[2][1]), 64'd101);
      check(early[2][3] == 32'd107, "t3_beat3", 64'(early[2][3]), 64'd107);

      // Random back-pressure and pause
      run_scan(1, 32'd100, 1'b1, 0, 1'b0, 1'b0, 2000, cyc);
      run_scan(2, 32'd100, 1'b1, 0, 1'b0, 1'b0, 5000, cyc);
      run_scan(1, 32'd100, 1'b1, 0, 1'b0, 1'b1, 2000, cyc);
      run_scan(1, $urandom, 1'b1, 0, 1'b0, 1'b0, 2000, cyc);

      // Address wrap
      run_scan(0, 32'hFFFF_FFF0, 1'b0, 0, 1'b0, 1'b0, 3000, cyc);
      check(first_a[0][24*32 +: 32] == 32'h0000_0080, "t5_wrap_e24",
            64'(first_a[0][24*32 +: 32]), 64'h80);

      // Reset mid-scan, start while busy, restart
      run_scan(0, 32'h0000_2000, 1'b0, 10, 1'b1, 1'b0, 3000, cyc);
      check(cnt[0] == 10, "t6_abort_point", 64'(cnt[0]), 64'd10);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check(!bsy[0] && !dn[0], "t6_idle_after_rst", {bsy[0], dn[0]}, 64'd0);
      run_scan(0, 32'h0000_2000, 1'b1, 0, 1'b0, 1'b0, 20000, cyc);
      check(cnt[0] == 961, "t6_beats", 64'(cnt[0]), 64'd961);
      check(first_a[0][31:0] == 32'h2000, "t6_restart_anchor",
            64'(first_a[0][31:0]), 64'h2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
